// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, pipeline latency and the fixed 16-colour palette.
package vga_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int PIPE_LAT = 4;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    localparam rgb12_t PALETTE [16] = '{
        rgb12_t'(12'h000), rgb12_t'(12'h00A), rgb12_t'(12'h0A0), rgb12_t'(12'h0AA),
        rgb12_t'(12'hA00), rgb12_t'(12'hA0A), rgb12_t'(12'hA50), rgb12_t'(12'hAAA),
        rgb12_t'(12'h555), rgb12_t'(12'h55F), rgb12_t'(12'h5F5), rgb12_t'(12'h5FF),
        rgb12_t'(12'hF55), rgb12_t'(12'hF5F), rgb12_t'(12'hFF5), rgb12_t'(12'hFFF)
    };

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical scan counters with raw (undelayed) sync, visible and frame-start flags.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    output logic [9:0] o_h_cnt,
    output logic [9:0] o_v_cnt,
    output logic       o_hsync_raw,
    output logic       o_vsync_raw,
    output logic       o_visible,
    output logic       o_frame_start_raw
);

    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_h_cnt <= 10'd0;
            r_v_cnt <= 10'd0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= 10'd0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    assign o_h_cnt           = r_h_cnt;
    assign o_v_cnt           = r_v_cnt;
    assign o_hsync_raw       = !((r_h_cnt >= HS_START) && (r_h_cnt < HS_END));
    assign o_vsync_raw       = !((r_v_cnt >= VS_START) && (r_v_cnt < VS_END));
    assign o_visible         = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
    assign o_frame_start_raw = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);

endmodule

// File: rtl/vga_pixel_pipeline.sv
// VGA scan-out: word fetch, 2-cycle read-latency absorption, 4bpp unpack and palette map.
module vga_pixel_pipeline
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic        clk_vga,
    input  logic        rst_n,
    output logic [15:0] vga_address,
    input  logic [31:0] vga_read_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_de,
    output logic        frame_start
);

    logic [9:0]  w_h_cnt;
    logic [9:0]  w_v_cnt;
    logic        w_hsync_raw;
    logic        w_vsync_raw;
    logic        w_visible;
    logic        w_frame_start_raw;
    logic [15:0] w_v_ext;
    logic [15:0] w_address;
    logic [3:0]  w_nibble;

    logic [15:0]         r_address;
    logic [2:0]          r_nib_d1;
    logic [2:0]          r_nib_d2;
    logic [2:0]          r_nib_d3;
    logic [PIPE_LAT-1:0] r_hs_pipe;
    logic [PIPE_LAT-1:0] r_vs_pipe;
    logic [PIPE_LAT-1:0] r_vis_pipe;
    logic [PIPE_LAT-1:0] r_fs_pipe;
    rgb12_t              r_rgb;

    vga_timing #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .i_clk             (clk_vga),
        .i_rst_n           (rst_n),
        .o_h_cnt           (w_h_cnt),
        .o_v_cnt           (w_v_cnt),
        .o_hsync_raw       (w_hsync_raw),
        .o_vsync_raw       (w_vsync_raw),
        .o_visible         (w_visible),
        .o_frame_start_raw (w_frame_start_raw)
    );

    // Line stride is 80 words; v*80 built as (v<<6)+(v<<4) to avoid a multiplier.
    assign w_v_ext   = {6'd0, w_v_cnt};
    assign w_address = w_visible ? ((w_v_ext << 6) + (w_v_ext << 4) + {9'd0, w_h_cnt[9:3]})
                                 : 16'd0;

    assign w_nibble = vga_read_data[{r_nib_d3, 2'b00} +: 4];

    always_ff @(posedge clk_vga) begin
        if (!rst_n) begin
            r_address  <= 16'd0;
            r_nib_d1   <= 3'd0;
            r_nib_d2   <= 3'd0;
            r_nib_d3   <= 3'd0;
            r_hs_pipe  <= '1;
            r_vs_pipe  <= '1;
            r_vis_pipe <= '0;
            r_fs_pipe  <= '0;
            r_rgb      <= '0;
        end else begin
            r_address  <= w_address;
            r_nib_d1   <= w_h_cnt[2:0];
            r_nib_d2   <= r_nib_d1;
            r_nib_d3   <= r_nib_d2;
            r_hs_pipe  <= {r_hs_pipe[PIPE_LAT-2:0], w_hsync_raw};
            r_vs_pipe  <= {r_vs_pipe[PIPE_LAT-2:0], w_vsync_raw};
            r_vis_pipe <= {r_vis_pipe[PIPE_LAT-2:0], w_visible};
            r_fs_pipe  <= {r_fs_pipe[PIPE_LAT-2:0], w_frame_start_raw};
            r_rgb      <= r_vis_pipe[PIPE_LAT-2] ? PALETTE[w_nibble] : '0;
        end
    end

    assign vga_address = r_address;
    assign vga_r       = r_rgb.r;
    assign vga_g       = r_rgb.g;
    assign vga_b       = r_rgb.b;
    assign vga_hsync   = r_hs_pipe[PIPE_LAT-1];
    assign vga_vsync   = r_vs_pipe[PIPE_LAT-1];
    assign vga_de      = r_vis_pipe[PIPE_LAT-1];
    assign frame_start = r_fs_pipe[PIPE_LAT-1];

endmodule

// File: tb/tb_vga_pixel_pipeline.sv
// Directed bench on a reduced raster (24x10 totals) with a 2-cycle registered memory model.
module tb_vga_pixel_pipeline;

    localparam int HV = 16, HF = 2, HS = 4, HB = 2;
    localparam int VV = 6,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk_vga = 1'b0;
    logic        rst_n   = 1'b0;
    logic [15:0] vga_address;
    logic [31:0] vga_read_data;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hsync, vga_vsync, vga_de, frame_start;

    logic [31:0] mem [0:511];
    logic [31:0] m1 = '0, m2 = '0;
    int k = 0;
    int n_err = 0;
    int n_chk = 0;

    vga_pixel_pipeline #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk_vga       (clk_vga),
        .rst_n         (rst_n),
        .vga_address   (vga_address),
        .vga_read_data (vga_read_data),
        .vga_r         (vga_r),
        .vga_g         (vga_g),
        .vga_b         (vga_b),
        .vga_hsync     (vga_hsync),
        .vga_vsync     (vga_vsync),
        .vga_de        (vga_de),
        .frame_start   (frame_start)
    );

    always #20 clk_vga = ~clk_vga;

    always @(posedge clk_vga) begin
        m1 <= mem[vga_address[8:0]];
        m2 <= m1;
    end
    assign vga_read_data = m2;

    // k = rising edges seen with rst_n high since the last reset
    always @(posedge clk_vga) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    task automatic goto(input int target);
        int guard = 0;
        while (k < target && guard < 5000) begin
            @(negedge clk_vga);
            guard++;
        end
        if (k < target) begin
            n_chk++;
            n_err++;
            $error("FAIL goto_timeout: observed k=%0d expected k=%0d", k, target);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"}, vga_address, 0);
        chk({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
        chk({tag, "_hs"}, vga_hsync, 1);
        chk({tag, "_vs"}, vga_vsync, 1);
        chk({tag, "_de"}, vga_de, 0);
        chk({tag, "_fs"}, frame_start, 0);
    endtask

    logic [11:0] exp_px [8];
    int hs_lo, de_hi, vs_lo, vs_run, vs_max, fs_n, hpos;
    int fs_at [4];

    initial begin
        exp_px = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA};
        for (int i = 0; i < 512; i++) mem[i] = 32'hFFFFFFFF;
        mem[0]  = 32'h76543210;
        mem[80] = 32'hFEDCBA98;

        rst_n = 1'b0;
        repeat (3) @(negedge clk_vga);
        chk_reset_vals("reset");
        rst_n = 1'b1;

        goto(1);
        chk("addr_h0_v0", vga_address, 0);
        goto(3);
        chk("pre_de", vga_de, 0);
        chk("pre_fs", frame_start, 0);
        goto(4);
        chk("first_fs", frame_start, 1);
        chk("first_de", vga_de, 1);
        for (int i = 0; i < 8; i++) begin
            goto(4 + i);
            chk("word0_px", {vga_r, vga_g, vga_b}, exp_px[i]);
            if (k == 8) chk("addr_h7", vga_address, 0);
            if (k == 9) chk("addr_h8", vga_address, 1);
        end
        goto(12);
        chk("ones_px", {vga_r, vga_g, vga_b}, 12'hFFF);
        chk("ones_de", vga_de, 1);

        // pixels h=16..23 of line 0 are blanking
        for (int t = 20; t < 28; t++) begin
            goto(t);
            hpos = t - 4;
            chk("blank_de", vga_de, 0);
            chk("blank_rgb", {vga_r, vga_g, vga_b}, 0);
            chk("blank_hs", vga_hsync, ((hpos >= 18) && (hpos < 22)) ? 0 : 1);
            if (t == 25) chk("addr_h0_v1", vga_address, 80);
            if (t == 22) chk("addr_blank", vga_address, 0);
        end
        goto(28);
        chk("line1_px0", {vga_r, vga_g, vga_b}, 12'h555);
        goto(29);
        chk("line1_px1", {vga_r, vga_g, vga_b}, 12'h55F);
        goto(136);
        chk("addr_last_vis", vga_address, 401);
        goto(137);
        chk("addr_after_last", vga_address, 0);

        hs_lo = 0; de_hi = 0; vs_lo = 0; vs_run = 0; vs_max = 0; fs_n = 0;
        fs_at = '{0, 0, 0, 0};
        for (int c = 0; c < 3 * FRAME; c++) begin
            goto(FRAME + 4 + c);
            if (c < FRAME) begin
                if (!vga_hsync) hs_lo++;
                if (vga_de) de_hi++;
                if (!vga_vsync) begin
                    vs_lo++;
                    vs_run++;
                    if (vs_run > vs_max) vs_max = vs_run;
                end else begin
                    vs_run = 0;
                end
            end
            if (frame_start) begin
                if (fs_n < 4) fs_at[fs_n] = k;
                fs_n++;
                chk("fs_with_de", vga_de, 1);
            end
        end
        chk("hs_low_count", hs_lo, HS * VT);
        chk("de_high_count", de_hi, HV * VV);
        chk("vs_low_count", vs_lo, VS * HT);
        chk("vs_low_run", vs_max, VS * HT);
        chk("fs_pulses", fs_n, 3);
        chk("fs_first_at", fs_at[0], FRAME + 4);
        chk("fs_gap1", fs_at[1] - fs_at[0], FRAME);
        chk("fs_gap2", fs_at[2] - fs_at[1], FRAME);

        // mid-frame reset at h=10, v=3 of the fifth frame
        goto(4 * FRAME + 3 * HT + 10);
        chk("midframe_de", vga_de, 1);
        chk("midframe_rgb", {vga_r, vga_g, vga_b}, 12'hFFF);
        rst_n = 1'b0;
        @(negedge clk_vga);
        chk_reset_vals("mid_rst1");
        repeat (2) @(negedge clk_vga);
        chk_reset_vals("mid_rst3");
        rst_n = 1'b1;
        goto(1);
        chk("rel_addr", vga_address, 0);
        goto(3);
        chk("rel_pre_de", vga_de, 0);
        chk("rel_pre_rgb", {vga_r, vga_g, vga_b}, 0);
        chk("rel_pre_fs", frame_start, 0);
        goto(4);
        chk("rel_fs", frame_start, 1);
        chk("rel_de", vga_de, 1);
        chk("rel_px0", {vga_r, vga_g, vga_b}, 12'h000);
        goto(5);
        chk("rel_px1", {vga_r, vga_g, vga_b}, 12'h00A);
        chk("rel_fs_end", frame_start, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
